// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight, tagged with the issuing thread ID, result
// returned through a valid/ack handshake.
module div_sequencer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [2:0]           i_funct3,
    input  logic [XLEN-1:0]      i_dividend,
    input  logic [XLEN-1:0]      i_divisor,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic                 i_flush,
    input  logic                 i_ack,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [XLEN-1:0]      o_result,
    output logic [TAG_WIDTH-1:0] o_tag
);

    localparam int unsigned CntW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFixup, StDone} state_e;

    state_e               state_q, state_d;
    logic [2:0]           funct3_q;
    logic [XLEN-1:0]      dvd_q;
    logic [XLEN-1:0]      dvs_q;     // raw divisor, replaced by |divisor| in PREP
    logic [XLEN-1:0]      quo_q;
    logic [XLEN-1:0]      rem_q;
    logic [CntW-1:0]      cnt_q;
    logic                 neg_quo_q, neg_rem_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [XLEN-1:0]      result_q;
    logic [TAG_WIDTH-1:0] res_tag_q;

    logic            is_signed, sel_rem;
    logic            dvd_neg, dvs_neg;
    logic [XLEN-1:0] dvd_abs, dvs_abs;
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   shifted, trial;
    logic            last_iter;
    logic [XLEN-1:0] fix_quo, fix_rem;

    // Operand decode, special-case detection and per-iteration datapath
    always_comb begin
        // Codes with funct3[2]=0 fall back to DIVU: unsigned, quotient
        is_signed   = i_funct3_sel_signed(funct3_q);
        sel_rem     = funct3_q[2] & funct3_q[1];
        dvd_neg     = is_signed & dvd_q[XLEN-1];
        dvs_neg     = is_signed & dvs_q[XLEN-1];
        dvd_abs     = dvd_neg ? -dvd_q : dvd_q;
        dvs_abs     = dvs_neg ? -dvs_q : dvs_q;
        div_zero    = (dvs_q == '0);
        sgn_ovf     = is_signed & (dvd_q == MinInt) & (dvs_q == '1);
        special     = div_zero | sgn_ovf;
        if (div_zero) begin
            special_res = sel_rem ? dvd_q : '1;
        end else begin
            special_res = sel_rem ? '0 : dvd_q;
        end
        shifted     = {rem_q, quo_q[XLEN-1]};
        trial       = shifted - {1'b0, dvs_q};
        last_iter   = (cnt_q == CntW'(XLEN - 1));
        fix_quo     = neg_quo_q ? -quo_q : quo_q;
        fix_rem     = neg_rem_q ? -rem_q : rem_q;
    end

    function automatic logic i_funct3_sel_signed(input logic [2:0] f);
        return f[2] & ~f[0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush aborts any in-flight or pending operation
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start && !i_flush) state_d = StPrep;
            StPrep:  begin
                if (i_flush)      state_d = StIdle;
                else if (special) state_d = StDone;
                else              state_d = StIter;
            end
            StIter:  begin
                if (i_flush)        state_d = StIdle;
                else if (last_iter) state_d = StFixup;
            end
            StFixup: state_d = i_flush ? StIdle : StDone;
            StDone:  if (i_flush || i_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        o_ready = (state_q == StIdle);
        o_busy  = (state_q == StPrep) || (state_q == StIter) || (state_q == StFixup);
        o_valid = (state_q == StDone);
    end

    // Operand capture, shift/subtract iterations and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q  <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            res_tag_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && !i_flush) begin
                        funct3_q <= i_funct3;
                        dvd_q    <= i_dividend;
                        dvs_q    <= i_divisor;
                        tag_q    <= i_tag;
                    end
                end
                StPrep: begin
                    if (!i_flush) begin
                        neg_quo_q <= dvd_neg ^ dvs_neg;
                        neg_rem_q <= dvd_neg;
                        if (special) begin
                            result_q  <= special_res;
                            res_tag_q <= tag_q;
                        end else begin
                            rem_q <= '0;
                            cnt_q <= '0;
                            quo_q <= dvd_abs;
                            dvs_q <= dvs_abs;
                        end
                    end
                end
                StIter: begin
                    // Remainder never exceeds the divisor, so XLEN bits hold it
                    if (!trial[XLEN]) begin
                        rem_q <= trial[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CntW'(1);
                end
                StFixup: begin
                    if (!i_flush) begin
                        result_q  <= sel_rem ? fix_rem : fix_quo;
                        res_tag_q <= tag_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result = result_q;
    assign o_tag    = res_tag_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic [2:0]  i_tag;
    logic        i_flush;
    logic        i_ack;
    logic        o_ready;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic [2:0]  o_tag;

    int n_checks = 0;
    int n_fail   = 0;

    div_sequencer #(
        .XLEN      (32),
        .TAG_WIDTH (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_funct3   (i_funct3),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_tag      (i_tag),
        .i_flush    (i_flush),
        .i_ack      (i_ack),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_tag      (o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division semantics from plain arithmetic.
    // Latency counts edges from the sampling edge to the first DONE cycle.
    task automatic ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output int lat);
        bit sgn, want_rem;
        sgn      = (f == 3'b100) || (f == 3'b110);
        want_rem = (f == 3'b110) || (f == 3'b111);
        if (b == 32'd0) begin
            res = want_rem ? a : 32'hFFFF_FFFF;
            lat = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = want_rem ? 32'd0 : a;
            lat = 2;
        end else if (sgn) begin
            res = want_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
            lat = 35;
        end else begin
            res = want_rem ? a % b : a / b;
            lat = 35;
        end
    endtask

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] t);
        @(negedge clk);
        i_start    = 1'b1;
        i_funct3   = f;
        i_dividend = a;
        i_divisor  = b;
        i_tag      = t;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the DUT must ignore them
        i_start    = 1'b0;
        i_funct3   = 3'($urandom);
        i_dividend = $urandom;
        i_divisor  = $urandom;
        i_tag      = 3'($urandom);
    endtask

    // Called #1 after the sampling edge; returns edge count until o_valid
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        i_ack = 1'b1;
        @(posedge clk);
        #1;
        i_ack = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] t);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        ref_model(f, a, b, exp_r, exp_lat);
        check_eq({nm, " ready"}, o_ready, 1'b1);
        start_op(f, a, b, t);
        wait_valid(lat);
        check_eq({nm, " latency"}, lat, exp_lat);
        check_eq({nm, " result"}, o_result, exp_r);
        check_eq({nm, " tag"}, o_tag, t);
        do_ack();
        check_eq({nm, " ready after ack"}, o_ready, 1'b1);
        check_eq({nm, " valid after ack"}, o_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int  lat;
        bit  seen;
        reset      = 1'b1;
        i_start    = 1'b0;
        i_funct3   = 3'b000;
        i_dividend = '0;
        i_divisor  = '0;
        i_tag      = '0;
        i_flush    = 1'b0;
        i_ack      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset ready", o_ready, 1'b1);
        check_eq("reset busy", o_busy, 1'b0);
        check_eq("reset valid", o_valid, 1'b0);
        check_eq("reset result", o_result, 32'd0);
        check_eq("reset tag", o_tag, 3'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases
        run_op("divu 100/7", 3'b101, 32'd100, 32'd7, 3'd3);
        run_op("remu 100/7", 3'b111, 32'd100, 32'd7, 3'd1);
        run_op("div -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 3'd2);
        run_op("rem -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 3'd4);
        run_op("rem 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 3'd5);
        run_op("div 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 3'd6);
        run_op("divu 5/0", 3'b101, 32'd5, 32'd0, 3'd7);
        run_op("rem 5/0", 3'b110, 32'd5, 32'd0, 3'd0);
        run_op("div ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 3'd1);
        run_op("rem ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2);
        run_op("code 000 as divu", 3'b000, 32'hFFFF_FFF9, 32'd2, 3'd3);

        // Backpressure: result held while ack withheld and starts ignored
        start_op(3'b101, 32'd100, 32'd7, 3'd3);
        wait_valid(lat);
        check_eq("bp latency", lat, 35);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_start    = (i % 2) == 0;
            i_funct3   = 3'b101;
            i_dividend = 32'd50;
            i_divisor  = 32'd5;
            i_tag      = 3'd6;
            @(posedge clk);
            #1;
            check_eq("bp valid held", o_valid, 1'b1);
            check_eq("bp result held", o_result, 32'd14);
            check_eq("bp tag held", o_tag, 3'd3);
            check_eq("bp ready low", o_ready, 1'b0);
        end
        i_start = 1'b0;
        do_ack();
        check_eq("bp ready after ack", o_ready, 1'b1);
        run_op("bp next op", 3'b101, 32'd50, 32'd5, 3'd6);

        // Flush on the 10th ITER cycle
        start_op(3'b101, 32'd1000, 32'd3, 3'd4);
        repeat (10) @(posedge clk);
        #1;
        check_eq("flush busy before", o_busy, 1'b1);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        check_eq("flush ready", o_ready, 1'b1);
        check_eq("flush busy", o_busy, 1'b0);
        check_eq("flush valid", o_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (o_valid) seen = 1'b1;
        end
        check_eq("flush no valid", seen, 1'b0);
        run_op("divu after flush", 3'b101, 32'hFFFF_FFFF, 32'h10, 3'd5);

        // Reset mid-ITER
        start_op(3'b101, 32'd77, 32'd3, 3'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst iter valid", o_valid, 1'b0);
        check_eq("rst iter busy", o_busy, 1'b0);
        check_eq("rst iter ready", o_ready, 1'b1);
        check_eq("rst iter result", o_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("remu after reset", 3'b111, 32'h1234_5678, 32'h100, 3'd7);

        // Flush together with start in IDLE: start ignored
        @(negedge clk);
        i_start  = 1'b1;
        i_flush  = 1'b1;
        i_funct3 = 3'b101;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_flush = 1'b0;
        check_eq("flush+start ready", o_ready, 1'b1);
        check_eq("flush+start busy", o_busy, 1'b0);

        // Flush together with ack in DONE
        start_op(3'b110, 32'd9, 32'd0, 3'd1);
        wait_valid(lat);
        check_eq("flush+ack result", o_result, 32'd9);
        @(negedge clk);
        i_flush = 1'b1;
        i_ack   = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_ack   = 1'b0;
        check_eq("flush+ack ready", o_ready, 1'b1);
        check_eq("flush+ack valid", o_valid, 1'b0);

        // Randomized operations, all funct3 codes
        for (int k = 0; k < 40; k++) begin
            run_op($sformatf("rand%0d", k), 3'($urandom), pick_operand(), pick_operand(),
                   3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
